// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - raw button levels in, conditioned press pulses out
interface button_conditioner_if;
    logic enter_btn;
    logic sign_btn;
    logic enter;
    logic sign;

    modport master (
        output enter_btn,
        output sign_btn,
        input  enter,
        input  sign
    );

    modport slave (
        input  enter_btn,
        input  sign_btn,
        output enter,
        output sign
    );
endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronize, debounce and edge-detect the enter and sign buttons
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    button_conditioner_if.slave  btn
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0] raw;
    assign raw = {btn.sign_btn, btn.enter_btn};

    // channel 0 = enter, channel 1 = sign; each channel has its own private state
    for (genvar i = 0; i < 2; i++) begin : g_ch
        logic          sync1;
        logic          sync2;
        logic          stable;
        logic [CW-1:0] cnt;
        logic          accept;
        logic          pulse;

        // sync2 has held the opposite level for DEBOUNCE_CYCLES consecutive edges
        assign accept = (sync2 != stable) && (cnt == CNT_MAX);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1  <= 1'b0;
                sync2  <= 1'b0;
                stable <= 1'b0;
                cnt    <= '0;
                pulse  <= 1'b0;
            end else begin
                sync1 <= raw[i];
                sync2 <= sync1;
                if (sync2 == stable) begin
                    cnt <= '0;
                end else if (accept) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                // only a rising accepted level makes a pulse; releases are silent
                pulse <= accept & sync2;
            end
        end
    end

    assign btn.enter = g_ch[0].pulse;
    assign btn.sign  = g_ch[1].pulse;
endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - randomized and directed checks of button_conditioner against a window model
module tb_button_conditioner;
    localparam int D = 4;

    logic clk;
    logic rst_n;

    button_conditioner_if bus();

    button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: a press/release is accepted once the last D synchronized samples
    // all differ from the accepted level; a pulse follows only a 0->1 acceptance.
    bit m_s1[2];
    bit m_s2[2];
    bit m_stable[2];
    bit m_pulse[2];
    bit hist[2][$];

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_stable[c] = 0; m_pulse[c] = 0;
            hist[c].delete();
        end
    endfunction

    function automatic void model_edge(input int c, input bit r);
        bit all_diff;
        m_pulse[c] = 0;
        hist[c].push_back(m_s2[c]);
        if (hist[c].size() > D) void'(hist[c].pop_front());
        all_diff = (hist[c].size() == D);
        for (int i = 0; i < hist[c].size(); i++)
            if (hist[c][i] == m_stable[c]) all_diff = 0;
        if (all_diff) begin
            m_stable[c] = m_s2[c];
            m_pulse[c]  = m_s2[c];
            hist[c].delete();
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = r;
    endfunction

    int cyc, enter_cnt, sign_cnt, enter_first, sign_first;

    task automatic clear_counts();
        cyc = 0; enter_cnt = 0; sign_cnt = 0; enter_first = 0; sign_first = 0;
    endtask

    task automatic step();
        bit re, rs;
        @(posedge clk);
        re = bus.enter_btn;
        rs = bus.sign_btn;
        if (!rst_n) model_reset();
        else begin
            model_edge(0, re);
            model_edge(1, rs);
        end
        #1;
        cyc++;
        check_val("enter", int'(bus.enter), int'(m_pulse[0]));
        check_val("sign", int'(bus.sign), int'(m_pulse[1]));
        if (bus.enter) begin enter_cnt++; if (enter_first == 0) enter_first = cyc; end
        if (bus.sign)  begin sign_cnt++;  if (sign_first == 0)  sign_first = cyc;  end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("rst_async_out", int'({bus.enter, bus.sign}), 0);
        run(2);
        check_val("rst_held_out", int'({bus.enter, bus.sign}), 0);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        int hold_e, hold_s;
        rst_n = 1'b0;
        bus.enter_btn = 1'b0;
        bus.sign_btn  = 1'b0;
        model_reset();
        clear_counts();
        run(2);
        check_val("reset_state", int'({bus.enter, bus.sign}), 0);
        #3 rst_n = 1'b1;
        run(4);

        // clean press: pulse visible after edge k+5
        bus.enter_btn = 1'b1;
        clear_counts();
        run(20);
        check_val("clean_first", enter_first, 6);
        check_val("clean_count", enter_cnt, 1);
        check_val("clean_sign", sign_cnt, 0);
        bus.enter_btn = 1'b0;
        run(12);

        // bounce 1,0,1,0 then held: single pulse 5 edges after final rise
        clear_counts();
        bus.enter_btn = 1'b1; step();
        bus.enter_btn = 1'b0; step();
        bus.enter_btn = 1'b1; step();
        bus.enter_btn = 1'b0; step();
        bus.enter_btn = 1'b1;
        run(16);
        check_val("bounce_first", enter_first, 10);
        check_val("bounce_count", enter_cnt, 1);
        bus.enter_btn = 1'b0;
        run(12);

        // glitch shorter than D
        clear_counts();
        bus.sign_btn = 1'b1;
        run(3);
        bus.sign_btn = 1'b0;
        run(12);
        check_val("glitch_count", sign_cnt, 0);

        // long hold, release, press again
        clear_counts();
        bus.enter_btn = 1'b1; run(50);
        check_val("hold_count", enter_cnt, 1);
        bus.enter_btn = 1'b0; run(10);
        check_val("release_count", enter_cnt, 1);
        bus.enter_btn = 1'b1; run(10);
        bus.enter_btn = 1'b0; run(12);
        check_val("repress_count", enter_cnt, 2);

        // simultaneous presses
        clear_counts();
        bus.enter_btn = 1'b1;
        bus.sign_btn  = 1'b1;
        run(12);
        check_val("simul_enter", enter_first, 6);
        check_val("simul_sign", sign_first, 6);
        check_val("simul_count", enter_cnt + sign_cnt, 2);
        bus.enter_btn = 1'b0;
        bus.sign_btn  = 1'b0;
        run(12);

        // reset mid-debounce with enter held (cnt == 2 after fourth edge)
        clear_counts();
        bus.enter_btn = 1'b1;
        run(4);
        check_val("midrst_pre", enter_cnt, 0);
        pulse_reset();
        clear_counts();
        run(12);
        check_val("midrst_first", enter_first, 6);
        check_val("midrst_count", enter_cnt, 1);
        bus.enter_btn = 1'b0;
        run(12);

        // randomized levels with random hold lengths and occasional resets
        hold_e = 0;
        hold_s = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold_e == 0) begin
                bus.enter_btn = 1'($urandom_range(0, 1));
                hold_e = int'($urandom_range(1, 9));
            end
            if (hold_s == 0) begin
                bus.sign_btn = 1'($urandom_range(0, 1));
                hold_s = int'($urandom_range(1, 9));
            end
            hold_e--;
            hold_s--;
            if ($urandom_range(0, 499) == 0) pulse_reset();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz), consecutive stable cycles required to accept a new level; legal range >= 2.
REQ-002 SHALL have port clk  input  1  system clock, single clock domain, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port enter_btn  input  1  raw asynchronous, bouncing enter push-button level, active high.
REQ-005 SHALL have port sign_btn  input  1  raw asynchronous, bouncing sign push-button level, active high.
REQ-006 SHALL have port enter  output  1  registered single-cycle pulse per accepted enter press; feeds ALU_ctrl enter.
REQ-007 SHALL have port sign  output  1  registered single-cycle pulse per accepted sign press; feeds ALU_ctrl sign.

Function
REQ-008 SHALL process the two channels with identical, fully independent logic; no shared counter or state.
REQ-009 SHALL pass each raw input through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-010 SHALL keep per channel a debounced level register "stable" and a counter cnt of width $clog2(DEBOUNCE_CYCLES).
REQ-011 SHALL, on an edge where sync2 == stable, load cnt with 0.
REQ-012 SHALL, on an edge where sync2 != stable and cnt < DEBOUNCE_CYCLES-1, increment cnt by 1.
REQ-013 SHALL, on an edge where sync2 != stable and cnt == DEBOUNCE_CYCLES-1, load stable with sync2 and cnt with 0.
REQ-014 SHALL drive the pulse output high for exactly the one cycle following an edge where stable changes 0->1; low otherwise.
REQ-015 SHALL NOT produce a pulse on an accepted 1->0 (release) transition.
REQ-016 SHALL NOT produce a pulse for any input excursion shorter than DEBOUNCE_CYCLES cycles at sync2; any return to the stable level restarts counting from 0.
REQ-017 SHALL produce exactly one pulse per accepted press regardless of hold duration; the next pulse requires an accepted release followed by an accepted press.
REQ-018 SHALL have latency: if raw input is high and held from sampling edge k, pulse is high in the cycle after edge k+1+DEBOUNCE_CYCLES.
REQ-019 SHALL never allow cnt to exceed DEBOUNCE_CYCLES-1 (no wrap-around).
REQ-020 SHALL, on simultaneous accepted presses of both channels, pulse enter and sign in the same cycle.

Reset
REQ-021 SHALL, while rst_n is low, asynchronously clear sync1, sync2, stable, cnt and both outputs to 0.
REQ-022 SHALL, on reset asserted mid-debounce, discard the partial count; no pulse in or after that reset for the interrupted press.
REQ-023 SHALL treat a button held through reset release as a new press: one pulse after the REQ-018 latency measured from the first edge after release.

Verification (DEBOUNCE_CYCLES=4)
REQ-024 SHALL cover a clean press: enter_btn 0->1 before edge k, held 20 cycles -> enter high only in the cycle after edge k+5, sign stays 0.
REQ-025 SHALL cover bounce: enter_btn toggles 1,0,1,0 for 1 cycle each then held high -> exactly one enter pulse, 5 edges after the final rise is sampled.
REQ-026 SHALL cover a glitch: sign_btn high for 3 cycles then low -> no sign pulse, cnt returns to 0.
REQ-027 SHALL cover a long hold and release: enter_btn high 50 cycles, low 10, high 10 -> exactly two enter pulses, none on release.
REQ-028 SHALL cover simultaneous presses: both buttons rise on the same edge -> enter and sign pulse in the same cycle.
REQ-029 SHALL cover mid-operation reset: rst_n pulsed low 2 cycles while cnt=2 with enter_btn held -> outputs 0 during reset, one enter pulse 5 edges after the first edge following rst_n release.
